// File: rtl/cal_op_sequencer.sv
// Two-requester round-robin sequencer for the calculator accumulator: load, add,
// shift-add multiply and restoring square root. Define CAL_OP_SEQUENCER_SAT_EN for saturating add/mul.
module cal_op_sequencer #(
  parameter int DATA_W = 8,
  parameter int OPND_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [1:0]        op0,
  input  logic [OPND_W-1:0] opnd0,
  output logic              ack0,
  input  logic              req1,
  input  logic [1:0]        op1,
  input  logic [OPND_W-1:0] opnd1,
  output logic              ack1,
  output logic [DATA_W-1:0] acc,
  output logic              busy,
  output logic              grant_id,
  output logic              ovf
);

  localparam int HALF_W = DATA_W / 2;
  localparam int PROD_W = DATA_W + OPND_W;
  localparam int KMAX   = (OPND_W > HALF_W) ? OPND_W : HALF_W;
  localparam int CNT_W  = $clog2(KMAX) + 1;
  localparam logic [CNT_W-1:0] MUL_LAST  = CNT_W'(OPND_W - 1);
  localparam logic [CNT_W-1:0] SQRT_LAST = CNT_W'(HALF_W - 1);

`ifdef CAL_OP_SEQUENCER_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  typedef enum logic [1:0] {OP_LOAD = 2'd0, OP_SQRT = 2'd1, OP_MUL = 2'd2, OP_ADD = 2'd3} op_t;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t              state, state_nxt;
  op_t                 op_q;
  logic [OPND_W-1:0]   opnd_q;
  logic [CNT_W-1:0]    cnt;
  logic                rr_ptr;
  logic                ovf_q;

  logic [PROD_W-1:0]   mcand, prod, prod_nxt;
  logic [OPND_W-1:0]   mplier;
  logic [DATA_W-1:0]   rad;
  logic [HALF_W:0]     rem, rem_nxt;
  logic [HALF_W-1:0]   root, root_nxt;
  logic [HALF_W+2:0]   rem_sh, trial;
  logic [DATA_W-1:0]   opnd_ext;
  logic [DATA_W:0]     sum;

  logic                grant_vld, grant_sel;
  logic [1:0]          op_sel;
  logic [OPND_W-1:0]   opnd_sel;
  logic                exec_last, over;
  logic [DATA_W-1:0]   result;

  // When both request, the pointer decides; otherwise the lone requester wins.
  assign grant_vld = req0 | req1;
  assign grant_sel = (req0 && req1) ? rr_ptr : req1;
  assign op_sel    = grant_sel ? op1 : op0;
  assign opnd_sel  = grant_sel ? opnd1 : opnd0;

  assign ovf = ovf_q;

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    prod_nxt = mplier[0] ? prod + mcand : prod;

    // One restoring-sqrt step: bring down two radicand bits, try subtracting 4*root+1.
    rem_sh   = {rem, rad[DATA_W-1 -: 2]};
    trial    = rem_sh - {1'b0, root, 2'b01};
    rem_nxt  = rem_sh[HALF_W:0];
    root_nxt = {root[HALF_W-2:0], 1'b0};
    if (!trial[HALF_W+2]) begin
      rem_nxt  = trial[HALF_W:0];
      root_nxt = {root[HALF_W-2:0], 1'b1};
    end

    opnd_ext = DATA_W'(opnd_q);
    sum      = {1'b0, acc} + {1'b0, opnd_ext};

    result    = opnd_ext;
    over      = 1'b0;
    exec_last = 1'b1;
    case (op_q)
      OP_LOAD: result = opnd_ext;
      OP_SQRT: begin
        result    = DATA_W'(root_nxt);
        exec_last = (cnt == SQRT_LAST);
      end
      OP_MUL: begin
        result    = prod_nxt[DATA_W-1:0];
        over      = |prod_nxt[PROD_W-1:DATA_W];
        exec_last = (cnt == MUL_LAST);
      end
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        over   = sum[DATA_W];
      end
      default: ;
    endcase
    if (SatEn && over) result = '1;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    ack0      = 1'b0;
    ack1      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (grant_vld) state_nxt = EXEC;
      end
      EXEC: if (exec_last) state_nxt = DONE;
      DONE: begin
        ack0      = ~grant_id;
        ack1      = grant_id;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      grant_id <= 1'b0;
      rr_ptr   <= 1'b0;
      ovf_q    <= 1'b0;
      op_q     <= OP_LOAD;
      opnd_q   <= '0;
      cnt      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      prod     <= '0;
      rad      <= '0;
      rem      <= '0;
      root     <= '0;
    end else begin
      case (state)
        IDLE: if (grant_vld) begin
          op_q     <= op_t'(op_sel);
          opnd_q   <= opnd_sel;
          cnt      <= '0;
          mcand    <= PROD_W'(acc);
          mplier   <= opnd_sel;
          prod     <= '0;
          rad      <= acc;
          rem      <= '0;
          root     <= '0;
          grant_id <= grant_sel;
          rr_ptr   <= ~grant_sel;
        end
        EXEC: begin
          cnt    <= cnt + 1'b1;
          prod   <= prod_nxt;
          mcand  <= {mcand[PROD_W-2:0], 1'b0};
          mplier <= {1'b0, mplier[OPND_W-1:1]};
          rem    <= rem_nxt;
          root   <= root_nxt;
          rad    <= {rad[DATA_W-3:0], 2'b00};
          if (exec_last) begin
            acc   <= result;
            ovf_q <= ovf_q | (SatEn & over);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cal_op_sequencer.sv
// Self-checking bench for cal_op_sequencer: directed scenarios with literal
// expectations, then randomized traffic against a cycle-countdown reference model.
module tb_cal_op_sequencer;

  localparam int DATA_W = 8;
  localparam int OPND_W = 4;
  localparam int MAXV   = (1 << DATA_W) - 1;
`ifdef CAL_OP_SEQUENCER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0 = 1'b0, req1 = 1'b0;
  logic [1:0]        op0 = '0, op1 = '0;
  logic [OPND_W-1:0] opnd0 = '0, opnd1 = '0;
  logic              ack0, ack1, busy, grant_id, ovf;
  logic [DATA_W-1:0] acc;

  always #5 clk = ~clk;

  cal_op_sequencer #(.DATA_W(DATA_W), .OPND_W(OPND_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .opnd0(opnd0), .ack0(ack0),
    .req1(req1), .op1(op1), .opnd1(opnd1), .ack1(ack1),
    .acc(acc), .busy(busy), .grant_id(grant_id), .ovf(ovf)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int isqrt(input int a);
    int r = 0;
    while ((r + 1) * (r + 1) <= a) r++;
    return r;
  endfunction

  function automatic int op_cycles(input int o);
    case (o)
      1:       return DATA_W / 2;
      2:       return OPND_W;
      default: return 1;
    endcase
  endfunction

  task automatic model_result(input int o, input int a, input int d, output int res, output bit ovset);
    int full;
    case (o)
      0:       full = d;
      1:       full = isqrt(a);
      2:       full = a * d;
      default: full = a + d;
    endcase
    ovset = 1'b0;
    if (full > MAXV) begin
      if (SAT) begin res = MAXV; ovset = 1'b1; end
      else     res = full % (MAXV + 1);
    end else res = full;
  endtask

  int m_acc = 0, m_gid = 0, m_ptr = 0, m_left = 0, m_res = 0;
  bit m_ovf = 0, m_done = 0, m_valid = 0, m_ovset = 0;
  int g_who, g_op, g_opnd;

  // m_left counts remaining EXEC cycles; m_done marks the single ack cycle.
  always @(posedge clk) begin
    if (rst) begin
      m_acc = 0; m_gid = 0; m_ptr = 0; m_ovf = 0; m_left = 0; m_done = 0; m_valid = 1;
    end else if (m_valid) begin
      if (m_done) m_done = 0;
      else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_acc  = m_res;
          m_ovf  = m_ovf | m_ovset;
          m_done = 1;
        end
      end else if (req0 || req1) begin
        g_who  = (req0 && req1) ? m_ptr : (req1 ? 1 : 0);
        g_op   = g_who ? int'(op1) : int'(op0);
        g_opnd = g_who ? int'(opnd1) : int'(opnd0);
        model_result(g_op, m_acc, g_opnd, m_res, m_ovset);
        m_left = op_cycles(g_op);
        m_gid  = g_who;
        m_ptr  = 1 - g_who;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("acc", acc, m_acc);
      check("busy", busy, (m_left > 0 || m_done) ? 1 : 0);
      check("ack0", ack0, (m_done && m_gid == 0) ? 1 : 0);
      check("ack1", ack1, (m_done && m_gid == 1) ? 1 : 0);
      check("grant_id", grant_id, m_gid);
      check("ovf", ovf, m_ovf);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int who, input bit v, input logic [1:0] o, input logic [OPND_W-1:0] d);
    if (who == 0) begin req0 = v; op0 = o; opnd0 = d; end
    else          begin req1 = v; op1 = o; opnd1 = d; end
  endtask

  task automatic wait_ack(input int who, output int lat);
    bit seen = 0;
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if ((who == 0 && ack0 === 1'b1) || (who == 1 && ack1 === 1'b1)) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL ack_timeout: requester %0d got no ack in 60 cycles, required one", who);
    end
  endtask

  task automatic wait_any(output int lat);
    bit seen = 0;
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL any_ack_timeout: got no ack in 60 cycles, required one");
    end
  endtask

  task automatic do_op(input int who, input logic [1:0] o, input logic [OPND_W-1:0] d, input int exp_lat);
    int lat;
    @(negedge clk);
    drive(who, 1'b1, o, d);
    wait_ack(who, lat);
    check("latency", lat, exp_lat);
    drive(who, 1'b0, o, d);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_acc", acc, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", {ack0, ack1}, 0);
    check("rst_gid", grant_id, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
  endtask

  initial begin
    int lat;

    // 1: reset, load 9
    pulse_rst();
    do_op(0, 2'd0, 4'd9, 2);
    check("t1_acc", acc, 9);
    check("t1_ack0", ack0, 1);
    @(negedge clk);
    check("t1_ack0_fall", ack0, 0);
    check("t1_busy_low", busy, 0);

    // 2: square roots
    do_op(0, 2'd1, 4'd0, 5);
    check("sqrt9", acc, 3);
    do_op(0, 2'd0, 4'd15, 2);
    do_op(0, 2'd2, 4'd13, 5);
    do_op(0, 2'd3, 4'd5, 2);
    check("acc200", acc, 200);
    do_op(0, 2'd1, 4'd0, 5);
    check("sqrt200", acc, 14);
    do_op(0, 2'd0, 4'd15, 2);
    do_op(0, 2'd2, 4'd15, 5);
    do_op(0, 2'd3, 4'd15, 2);
    do_op(0, 2'd3, 4'd15, 2);
    check("acc255", acc, 255);
    do_op(0, 2'd1, 4'd0, 5);
    check("sqrt255", acc, 15);
    do_op(0, 2'd0, 4'd0, 2);
    do_op(0, 2'd1, 4'd0, 5);
    check("sqrt0", acc, 0);

    // 3: 20 * 13
    do_op(0, 2'd0, 4'd5, 2);
    do_op(0, 2'd2, 4'd4, 5);
    check("acc20", acc, 20);
    do_op(1, 2'd2, 4'd13, 5);
    check("mul_20x13", acc, SAT ? 255 : 4);
    check("mul_ovf", ovf, SAT ? 1 : 0);

    // 4: simultaneous requests from reset
    pulse_rst();
    drive(0, 1'b1, 2'd0, 4'd5);
    drive(1, 1'b1, 2'd3, 4'd3);
    wait_any(lat);
    check("rr_first_ack0", {ack0, ack1}, 2'b10);
    check("rr_first_acc", acc, 5);
    check("rr_first_gid", grant_id, 0);
    drive(0, 1'b0, 2'd0, 4'd0);
    wait_ack(1, lat);
    check("rr_second_acc", acc, 8);
    check("rr_second_gid", grant_id, 1);
    drive(1, 1'b0, 2'd0, 4'd0);
    @(negedge clk);
    drive(0, 1'b1, 2'd0, 4'd7);
    drive(1, 1'b1, 2'd0, 4'd9);
    wait_any(lat);
    check("rr_again_ack0", {ack0, ack1}, 2'b10);
    check("rr_again_acc", acc, 7);
    drive(0, 1'b0, 2'd0, 4'd0);
    wait_ack(1, lat);
    check("rr_again_acc1", acc, 9);
    drive(1, 1'b0, 2'd0, 4'd0);

    // 5: reset during the second EXEC cycle of a multiply
    do_op(0, 2'd0, 4'd5, 2);
    do_op(0, 2'd2, 4'd4, 5);
    @(negedge clk);
    drive(0, 1'b1, 2'd2, 4'd13);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b0, 2'd2, 4'd13);
    @(negedge clk);
    check("abort_acc", acc, 0);
    check("abort_busy", busy, 0);
    check("abort_ack", {ack0, ack1}, 0);
    rst = 1'b0;
    drive(0, 1'b1, 2'd0, 4'd1);
    drive(1, 1'b1, 2'd0, 4'd2);
    wait_any(lat);
    check("abort_ptr0", {ack0, ack1}, 2'b10);
    drive(0, 1'b0, 2'd0, 4'd0);
    wait_ack(1, lat);
    drive(1, 1'b0, 2'd0, 4'd0);

    // 6: 250 + 9, then load keeps ovf
    do_op(0, 2'd0, 4'd10, 2);
    do_op(0, 2'd2, 4'd5, 5);
    do_op(0, 2'd2, 4'd5, 5);
    check("acc250", acc, 250);
    do_op(1, 2'd3, 4'd9, 2);
    check("add_250_9", acc, SAT ? 255 : 3);
    check("add_ovf", ovf, SAT ? 1 : 0);
    do_op(0, 2'd0, 4'd2, 2);
    check("load_after_ovf", acc, 2);
    check("ovf_sticky", ovf, SAT ? 1 : 0);
    pulse_rst();

    // randomized traffic, model-checked every cycle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      for (int w = 0; w < 2; w++) begin
        bit cur = (w == 0) ? req0 : req1;
        if (cur && m_done && m_gid == w) begin
          if ($urandom_range(0, 2) == 0)
            drive(w, 1'b1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
          else
            drive(w, 1'b0, 2'd0, 4'd0);
        end else if (!cur && $urandom_range(0, 3) == 0) begin
          drive(w, 1'b1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cal_op_sequencer.md
Name: cal_op_sequencer

Overview:
- Sequences the calculator's accumulator datapath (load / square-root / multiply / add) and shares it between two requesters, e.g. the button panel and a serial command source.
- Round-robin arbitration with a req/ack handshake per requester.
- Multiply and square-root run as multi-cycle iterative units: shift-add multiply and restoring square root. There is no combinational multiplier or sqrt.
- Sits between the input front-ends and the LED/result display; acc drives the display.

Parameters:
- DATA_W, 8: accumulator width. Must be even.
- OPND_W, 4: operand width (switch value), zero-extended to DATA_W.

Ports:
- clk  in  1: system clock; all logic on posedge.
- rst  in  1: reset, synchronous, active-high.
- req0  in  1: requester 0 request; held with op0/opnd0 stable until ack0.
- op0  in  2: requester 0 opcode: 0 load, 1 sqrt, 2 mul, 3 add.
- opnd0  in  OPND_W: requester 0 operand.
- ack0  out  1: one-cycle completion pulse to requester 0.
- req1, op1, opnd1, ack1: same as above, for requester 1.
- acc  out  DATA_W: accumulator / result.
- busy  out  1: high in every state except IDLE.
- grant_id  out  1: requester last granted; held until the next grant.
- ovf  out  1: sticky overflow flag (see Optional Feature).

Behaviour:
- Reset values (rst high at a clock edge): state IDLE, acc 0, ack0/ack1 0, busy 0, grant_id 0, ovf 0, round-robin pointer 0 (requester 0 preferred).
- Reset mid-operation: the operation is abandoned, no ack is issued, and acc is cleared.
- States: IDLE -> EXEC -> DONE -> IDLE.
- IDLE:
  - If only one req is high, grant it.
  - If both are high, grant the requester named by the pointer.
  - On grant: latch op, operand (zero-extended) and acc into working registers; set grant_id; set pointer to the other requester; go to EXEC.
- EXEC lasts K cycles:
  - load: K=1, result = operand.
  - add: K=1, result = (acc + operand) mod 2^DATA_W.
  - mul: K=OPND_W. One operand bit per cycle, LSB first, shift-add. Result = (acc*operand) mod 2^DATA_W.
  - sqrt: K=DATA_W/2. Restoring algorithm, 2 bits per cycle. Result = floor(sqrt(acc)), zero-extended.
- EXEC last cycle -> DONE: acc is updated at that edge.
- DONE: ack of the granted requester is high for exactly this one cycle; the next edge returns to IDLE.
- Timing: if the IDLE grant occurs at edge E, acc updates and ack rises at edge E+K, and ack falls at E+K+1.
- The earliest next grant is edge E+K+2. This gives the requester the DONE cycle to drop req. A req still high in IDLE is a new request.
- Back-to-back throughput: one operation per K+2 cycles.
- req and operand changes during EXEC/DONE are ignored; only the values latched at grant are used.
- A req from the non-granted requester stays pending with no timeout. Its ack is never asserted until it is granted.
- Opcode is 2 bits, so all values are defined.

Optional Feature:
- Macro CAL_OP_SEQUENCER_SAT_EN.
- Defined:
  - add and mul saturate to 2^DATA_W-1 when the true result exceeds it.
  - ovf is set at the acc-update edge of any saturating operation and stays high until rst.
  - load and sqrt never set ovf.
- Undefined:
  - add and mul wrap modulo 2^DATA_W.
  - ovf is constant 0; the port is still present.

Test Plan:
1. Reset, then req0 load 9 granted at edge E: acc=9 and ack0=1 at E+1, ack0=0 at E+2, busy low from E+2.
2. acc=9, req0 sqrt: acc=3 at E+4. Repeat from acc=200 -> 14, and from acc=255 -> 15. Check 0 -> 0.
3. acc=20, req1 mul 13, acc updated at E+4: acc=4 with ovf=0 when wrapping; acc=255 with ovf=1 when SAT_EN is defined.
4. From reset, req0 load 5 and req1 add 3 raised in the same cycle: ack0 first (acc=5, grant_id=0), then ack1 (acc=8, grant_id=1). Re-raise both: requester 1 is not favoured; requester 0 is granted (pointer=0).
5. acc=20, mul 13 started; assert rst during the 2nd EXEC cycle: no ack, acc=0, busy=0, pointer=0 on the next cycle.
6. acc=250, add 9: acc=3 when wrapping; acc=255 and ovf=1 with SAT_EN. A following load 2 leaves ovf=1 until rst.
